// File: rtl/periferico_bin2bcd.sv
// periferico_bin2bcd
//
// Memory-mapped binary-to-BCD converter for the calculator datapath.
// Firmware writes a 32-bit operand as two 16-bit halves and then starts a
// conversion through INIT. A sequential double-dabble engine then runs 32
// iterations (add-3 adjust, then shift) and produces 10 packed BCD digits.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-low; clears all state
//   d_in   in  16   write data
//   cs     in   1   chip select
//   addr   in   5   register address
//   rd     in   1   read strobe (qualified by cs)
//   wr     in   1   write strobe (qualified by cs, sampled at posedge)
//   d_out  out 32   combinational read data, 0 when not selected
//
// Register map:
//   0x04 BIN_LO (W)  operand[15:0]
//   0x08 BIN_HI (W)  operand[31:16]
//   0x0C INIT   (W)  d_in[0]=1 starts a conversion (ignored while busy)
//   0x10 BCD_LO (R)  digits 7..0
//   0x14 BCD_HI (R)  {24'b0, digit 9, digit 8}
//   0x18 STATUS (R)  {30'b0, busy, done}
//
// Bus handshake: a write is a single-cycle strobe (cs&&wr) that takes effect
// at the next rising edge; there is no backpressure. A read (cs&&rd) returns
// the current (pre-edge) register value combinationally in the same cycle.

module periferico_bin2bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam logic [4:0] ADDR_BIN_LO = 5'h04;
  localparam logic [4:0] ADDR_BIN_HI = 5'h08;
  localparam logic [4:0] ADDR_INIT   = 5'h0C;
  localparam logic [4:0] ADDR_BCD_LO = 5'h10;
  localparam logic [4:0] ADDR_BCD_HI = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [39:0] res_q, res_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        wr_en;
  logic        init_req;
  logic [39:0] bcd_adj;
  logic [39:0] bcd_shift;

  assign wr_en    = cs && wr;
  assign init_req = wr_en && (addr == ADDR_INIT) && d_in[0];

  // Add-3 adjust on every digit that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // {bcd, bin} shifted left by one: the binary MSB enters the BCD LSB.
  assign bcd_shift = {bcd_adj[38:0], bin_q[31]};

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = done_q;

    // Operand writes are accepted in every state; a running conversion works
    // from its own copy in bin_q, so it is unaffected.
    if (wr_en && (addr == ADDR_BIN_LO)) begin
      operand_d[15:0] = d_in;
    end
    if (wr_en && (addr == ADDR_BIN_HI)) begin
      operand_d[31:16] = d_in;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (init_req) begin
          bin_d   = operand_q;
          bcd_d   = 40'h0;
          cnt_d   = 5'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        // Iteration 31 is the last one; publish its post-shift result.
        if (cnt_q == 5'd31) begin
          res_d   = bcd_shift;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      operand_q <= 32'h0;
      bin_q     <= 32'h0;
      bcd_q     <= 40'h0;
      cnt_q     <= 5'd0;
      res_q     <= 40'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Read mux: write-only and unmapped addresses read as zero.
  always_comb begin
    d_out = 32'h0;
    if (cs && rd) begin
      case (addr)
        ADDR_BCD_LO: d_out = res_q[31:0];
        ADDR_BCD_HI: d_out = {24'h0, res_q[39:32]};
        ADDR_STATUS: d_out = {30'h0, busy_q, done_q};
        default:     d_out = 32'h0;
      endcase
    end
  end

endmodule

// File: doc/periferico_bin2bcd.md
# periferico_bin2bcd

Memory-mapped binary-to-BCD conversion peripheral for the calculator datapath, sitting directly downstream of the multiplier peripheral. Firmware copies the 32-bit product into this block and pulses INIT. The block then runs a sequential double-dabble conversion (add-3 adjust plus shift) into 10 packed BCD digits for the display driver. It uses the same cs/rd/wr/addr bus protocol as the other calculator peripherals.

## Interface
- No parameters. Operand width is fixed at 32 bits, result at 10 BCD digits (40 bits).
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low. Port named `reset`; low clears all state immediately.
- d_in  in  16  write data.
- cs  in  1  chip select.
- addr  in  5  register address.
- rd  in  1  read strobe, effective with cs.
- wr  in  1  write strobe; sampled at posedge when cs=1.
- d_out  out  32  read data; combinational.

## Operation
- Register map (addr):
  - 0x04 BIN_LO (W): operand[15:0] ← d_in.
  - 0x08 BIN_HI (W): operand[31:16] ← d_in.
  - 0x0C INIT (W): d_in[0]=1 starts a conversion.
  - 0x10 BCD_LO (R): digits 7..0, digit 0 in bits [3:0].
  - 0x14 BCD_HI (R): {24'b0, digit 9, digit 8}.
  - 0x18 STATUS (R): {30'b0, busy, done}.
- Read path: d_out = selected register when cs&&rd, else 32'h0. Unmapped addresses read 0. Write-only addresses read 0.
- FSM states:
  - IDLE:
    - Valid INIT (cs&&wr, addr 0x0C, d_in[0]=1): load shift register bin ← operand, clear 40-bit BCD accumulator, cnt ← 0, done ← 0, busy ← 1; go to SHIFT.
  - SHIFT, per cycle:
    - Each of the 10 digits ≥5 gets +3.
    - Then {bcd,bin} shifts left by 1.
    - cnt ← cnt+1.
    - When cnt==31, this iteration is the last: copy the post-shift bcd into the result registers, done ← 1, busy ← 0; go to DONE.
  - DONE: behaves as IDLE; a valid INIT restarts conversion.
- Result registers BCD_LO/BCD_HI change only on completion and hold their value until the next completion. Partial values are never visible.
- Width rule: every 32-bit operand fits in 10 digits (max 4294967295). Digit 9 is never above 4, so no overflow handling is needed.

## Timing
- Reset values: state IDLE; operand, shift register, accumulator, cnt, result registers = 0; busy=0; done=0. d_out=0 whenever not selected.
- Latency: INIT sampled at edge E. Iterations run at edges E+1..E+32. done=1 and results are valid after edge E+32. busy=1 after edges E..E+31.
- INIT while busy is ignored; the conversion in progress continues unaffected.
- INIT with d_in[0]=0 is ignored in every state.
- BIN_LO/BIN_HI writes while busy update the operand register only. The running conversion uses the value latched at E.
- done stays 1 until the next accepted INIT clears it, at the same edge that sets busy.
- Simultaneous cs&&wr&&rd: the write takes effect at the edge. d_out shows the pre-edge register value during that cycle.
- Reset asserted mid-conversion: immediate return to the reset values. No completion and no done are produced. A fresh INIT is required afterwards.

## Test plan
- Multiplier product: BIN_LO=0x3AFA, BIN_HI=0x0005 (342778 = 934·367), INIT → done after 32 cycles; BCD_LO=0x00342778, BCD_HI=0x00000000.
- Maximum value: BIN_LO=0xFFFF, BIN_HI=0xFFFF, INIT → BCD_LO=0x94967295, BCD_HI=0x00000042.
- Zero and latency check: operand 0, INIT → BCD_LO=0, BCD_HI=0. STATUS reads 0x2 for exactly 32 cycles, then 0x1.
- Busy protection: start with 65535·65535=4294836225, then during SHIFT write BIN_LO=0x0001 and INIT → result BCD_HI=0x42, BCD_LO=0x94836225. A second INIT then converts the new operand.
- Reset mid-operation: assert reset low at cycle 10 of a conversion → STATUS=0, BCD_LO=0 immediately. After reset releases, INIT with operand 9 → BCD_LO=0x00000009.
- Bus edge cases: read addr 0x1C and 0x04 → 0. With rd=0, d_out=0. INIT with d_in=0x0002 → no start, STATUS unchanged.
